// File: rtl/seq_multiplier_taint_hs.sv
// Sequential shift-add multiplier with K-bit radix, optional signed mode,
// optional early exit, valid/ready handshakes and split data/control taint.
module seq_multiplier_taint_hs #(
    parameter int WIDTH      = 32,
    parameter int K          = 1,
    parameter int EARLY_EXIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_valid_t,
    output logic               in_ready,
    output logic               in_ready_t,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic               multiplier_t,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic               multiplicand_t,
    input  logic               signed_mode,
    input  logic               signed_mode_t,
    output logic               out_valid,
    output logic               out_valid_t,
    input  logic               out_ready,
    input  logic               out_ready_t,
    output logic [2*WIDTH-1:0] product,
    output logic               product_t,
    output logic               busy
);

    localparam int NITER = WIDTH / K;
    localparam int CW    = $clog2(NITER + 1);
    localparam int PW    = 2 * WIDTH;

    generate
        if (K < 1 || (WIDTH % K) != 0) begin : g_bad_radix
            $error("seq_multiplier_taint_hs: WIDTH must be a multiple of K");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             data_t_q, data_t_d;
    logic             ctrl_t_q, ctrl_t_d;
    logic [PW-1:0]    product_q, product_d;
    logic             product_t_q, product_t_d;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [PW-1:0]    partial;
    logic             ee_on;

    assign ee_on = (EARLY_EXIT != 0);

    // Operand magnitudes; the most negative value maps onto 2^(WIDTH-1) unchanged.
    always_comb begin
        mag_a = multiplier;
        mag_b = multiplicand;
        if (signed_mode && multiplier[WIDTH-1]) mag_a = -multiplier;
        if (signed_mode && multiplicand[WIDTH-1]) mag_b = -multiplicand;
    end

    // Partial product for the low K multiplier bits, as K shifted adds.
    always_comb begin
        partial = '0;
        for (int unsigned j = 0; j < K; j++) begin
            if (mplier_q[j]) partial = partial + (mcand_q << j);
        end
    end

    // Next-state and datapath updates for IDLE/CALC/DONE.
    always_comb begin
        state_d     = state_q;
        mplier_d    = mplier_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        data_t_d    = data_t_q;
        ctrl_t_d    = ctrl_t_q;
        product_d   = product_q;
        product_t_d = product_t_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mplier_d = mag_a;
                    mcand_d  = {{WIDTH{1'b0}}, mag_b};
                    acc_d    = '0;
                    cnt_d    = '0;
                    neg_d    = signed_mode & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
                    data_t_d = multiplier_t | multiplicand_t | signed_mode_t;
                    ctrl_t_d = in_valid_t | (ee_on & multiplier_t);
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                acc_d    = acc_q + partial;
                mcand_d  = mcand_q << K;
                mplier_d = mplier_q >> K;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_d == CW'(NITER) || (ee_on && mplier_d == '0)) begin
                    product_d   = neg_q ? -acc_d : acc_d;
                    product_t_d = data_t_q;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    if (out_ready_t) ctrl_t_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mplier_q    <= '0;
            mcand_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            data_t_q    <= 1'b0;
            ctrl_t_q    <= 1'b0;
            product_q   <= '0;
            product_t_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mplier_q    <= mplier_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            data_t_q    <= data_t_d;
            ctrl_t_q    <= ctrl_t_d;
            product_q   <= product_d;
            product_t_q <= product_t_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign in_ready_t  = ctrl_t_q;
    assign out_valid_t = ctrl_t_q;
    assign product     = product_q;
    assign product_t   = product_t_q;

endmodule

// File: tb/tb_seq_multiplier_taint_hs.sv
// Bench for seq_multiplier_taint_hs: three parameterisations driven in lockstep
// from shared inputs, checked against an arithmetic reference model.
module tb_seq_multiplier_taint_hs;

    localparam int WA [3] = '{8, 8, 16};
    localparam int KA [3] = '{1, 1, 4};
    localparam int EA [3] = '{0, 1, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, in_valid_t = 1'b0;
    logic out_ready = 1'b0, out_ready_t = 1'b0;
    logic sm = 1'b0, sm_t = 1'b0, mt = 1'b0, bt = 1'b0;
    logic [15:0] a_in = '0, b_in = '0;

    logic ir [3], irt [3], ov [3], ovt [3], pt [3], by [3];
    logic [15:0] p0, p1;
    logic [31:0] p2;

    int  n_tests = 0;
    int  n_fail  = 0;
    logic exp_ctrl [3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    seq_multiplier_taint_hs #(.WIDTH(WA[0]), .K(KA[0]), .EARLY_EXIT(EA[0])) d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_valid_t(in_valid_t),
        .in_ready(ir[0]), .in_ready_t(irt[0]),
        .multiplier(a_in[7:0]), .multiplier_t(mt), .multiplicand(b_in[7:0]), .multiplicand_t(bt),
        .signed_mode(sm), .signed_mode_t(sm_t), .out_valid(ov[0]), .out_valid_t(ovt[0]),
        .out_ready(out_ready), .out_ready_t(out_ready_t), .product(p0), .product_t(pt[0]), .busy(by[0]));

    seq_multiplier_taint_hs #(.WIDTH(WA[1]), .K(KA[1]), .EARLY_EXIT(EA[1])) d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_valid_t(in_valid_t),
        .in_ready(ir[1]), .in_ready_t(irt[1]),
        .multiplier(a_in[7:0]), .multiplier_t(mt), .multiplicand(b_in[7:0]), .multiplicand_t(bt),
        .signed_mode(sm), .signed_mode_t(sm_t), .out_valid(ov[1]), .out_valid_t(ovt[1]),
        .out_ready(out_ready), .out_ready_t(out_ready_t), .product(p1), .product_t(pt[1]), .busy(by[1]));

    seq_multiplier_taint_hs #(.WIDTH(WA[2]), .K(KA[2]), .EARLY_EXIT(EA[2])) d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_valid_t(in_valid_t),
        .in_ready(ir[2]), .in_ready_t(irt[2]),
        .multiplier(a_in), .multiplier_t(mt), .multiplicand(b_in), .multiplicand_t(bt),
        .signed_mode(sm), .signed_mode_t(sm_t), .out_valid(ov[2]), .out_valid_t(ovt[2]),
        .out_ready(out_ready), .out_ready_t(out_ready_t), .product(p2), .product_t(pt[2]), .busy(by[2]));

    function automatic logic [31:0] prod(input int i);
        case (i)
            0:       return {16'h0000, p0};
            1:       return {16'h0000, p1};
            default: return p2;
        endcase
    endfunction

    // Product of the low w bits of a and b as integers, wrapped to 2w bits.
    function automatic logic [31:0] ref_prod(input int w, input logic sgn,
                                             input logic [15:0] a, input logic [15:0] b);
        longint av, bv, p, m;
        m  = (longint'(1) << w) - 1;
        av = longint'(a) & m;
        bv = longint'(b) & m;
        if (sgn && av >= (longint'(1) << (w - 1))) av = av - (longint'(1) << w);
        if (sgn && bv >= (longint'(1) << (w - 1))) bv = bv - (longint'(1) << w);
        p = av * bv;
        return 32'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    // Edges from accept to out_valid: fixed, or number of significant K-bit chunks of |A|.
    function automatic int ref_lat(input int i, input logic sgn, input logic [15:0] a);
        longint mag, m;
        int bits, n;
        if (EA[i] == 0) return WA[i] / KA[i];
        m   = (longint'(1) << WA[i]) - 1;
        mag = longint'(a) & m;
        if (sgn && mag >= (longint'(1) << (WA[i] - 1))) mag = (longint'(1) << WA[i]) - mag;
        bits = 0;
        while (mag != 0) begin
            mag = mag >> 1;
            bits++;
        end
        n = (bits + KA[i] - 1) / KA[i];
        return (n < 1) ? 1 : n;
    endfunction

    task automatic chk(input string nm, input int i, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, i, act, exp);
        end
    endtask

    // One full transaction on all three DUTs; optional DONE stall with in_valid pressure.
    task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                           input logic t_a, input logic t_b, input logic t_s, input logic t_v,
                           input int hold, input logic ort, output logic [31:0] got0);
        int lat [3];
        logic [31:0] held [3];
        logic dt;
        bit all_seen;
        a_in = a; b_in = b; sm = sgn; mt = t_a; bt = t_b; sm_t = t_s; in_valid_t = t_v;
        in_valid = 1'b1;
        @(posedge clk);
        dt = t_a | t_b | t_s;
        for (int i = 0; i < 3; i++) exp_ctrl[i] = t_v | ((EA[i] != 0) & t_a);
        @(negedge clk);
        in_valid = 1'b0;
        lat = '{0, 0, 0};
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            all_seen = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (lat[i] == 0 && ov[i]) lat[i] = cyc;
                if (lat[i] == 0) all_seen = 1'b0;
            end
            if (all_seen) break;
        end
        for (int i = 0; i < 3; i++) begin
            chk("latency", i, lat[i], ref_lat(i, sgn, a));
            chk("product", i, prod(i), ref_prod(WA[i], sgn, a, b));
            chk("product_t", i, pt[i], dt);
            chk("out_valid_t", i, ovt[i], exp_ctrl[i]);
            chk("in_ready_done", i, ir[i], 0);
            held[i] = prod(i);
        end
        got0 = prod(0);
        for (int h = 0; h < hold; h++) begin
            a_in = 16'($urandom); b_in = 16'($urandom);
            in_valid = 1'b1; out_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk("hold_product", i, prod(i), held[i]);
                chk("hold_valid", i, ov[i], 1);
                chk("hold_in_ready", i, ir[i], 0);
            end
        end
        in_valid = (hold > 0);
        out_ready = 1'b1; out_ready_t = ort;
        @(posedge clk);
        if (ort) for (int i = 0; i < 3; i++) exp_ctrl[i] = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; out_ready_t = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("hs_in_ready", i, ir[i], 1);
            chk("hs_out_valid", i, ov[i], 0);
            chk("hs_busy", i, by[i], 0);
            chk("hs_in_ready_t", i, irt[i], exp_ctrl[i]);
            chk("idle_product", i, prod(i), held[i]);
        end
    endtask

    typedef struct {
        logic [15:0] a, b;
        logic        sgn, ta, tb, ts, tv;
        logic [15:0] exp_p0;
        logic        exp_pt;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] g;
        tbl[0] = '{16'h00C8, 16'h0096, 0, 0, 0, 0, 0, 16'h7530, 0};
        tbl[1] = '{16'hFF80, 16'hFF80, 1, 0, 0, 0, 0, 16'h4000, 0};
        tbl[2] = '{16'hFFFD, 16'h0005, 1, 0, 0, 0, 0, 16'hFFF1, 0};
        tbl[3] = '{16'h00FF, 16'h00FF, 0, 0, 0, 0, 0, 16'hFE01, 0};
        tbl[4] = '{16'h0003, 16'h0007, 0, 1, 0, 0, 0, 16'h0015, 1};
        tbl[5] = '{16'h0003, 16'h0007, 0, 0, 1, 0, 0, 16'h0015, 1};
        tbl[6] = '{16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 0, 16'hFE01, 0};
        tbl[7] = '{16'h0000, 16'h1234, 0, 0, 0, 1, 0, 16'h0000, 1};
        tbl[8] = '{16'h0005, 16'hFFFF, 1, 0, 0, 0, 1, 16'hFFFB, 0};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready", i, ir[i], 1);
            chk("rst_out_valid", i, ov[i], 0);
            chk("rst_busy", i, by[i], 0);
            chk("rst_product", i, prod(i), 0);
            chk("rst_taints", i, {pt[i], ovt[i], irt[i]}, 0);
        end
        rst = 1'b0;

        for (int v = 0; v < 9; v++) begin
            run_txn(tbl[v].a, tbl[v].b, tbl[v].sgn, tbl[v].ta, tbl[v].tb, tbl[v].ts, tbl[v].tv,
                    0, 1'b0, g);
            chk("tbl_product", 0, g[15:0], tbl[v].exp_p0);
            chk("tbl_product_t", 0, pt[0], tbl[v].exp_pt);
        end

        // Stall in DONE with in_valid pressure, then a tainted out_ready handshake.
        run_txn(16'h0012, 16'h0034, 0, 0, 0, 0, 0, 5, 1'b1, g);
        chk("stall_product", 0, g, 32'h03A8);
        chk("stall_in_ready_t", 0, irt[0], 1);
        // ctrl taint is reloaded by the next accept.
        run_txn(16'h0021, 16'h0002, 0, 0, 0, 0, 0, 0, 1'b0, g);

        // Reset asserted during the third CALC cycle.
        a_in = 16'h00FF; b_in = 16'h0F0F; sm = 0; mt = 1; bt = 1; sm_t = 1; in_valid_t = 1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) chk("pre_rst_busy", i, by[i], 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_ctrl[i] = 1'b0;
            chk("midrst_out_valid", i, ov[i], 0);
            chk("midrst_in_ready", i, ir[i], 1);
            chk("midrst_product", i, prod(i), 0);
            chk("midrst_taints", i, {pt[i], ovt[i], irt[i]}, 0);
        end
        run_txn(16'h0081, 16'h0077, 1, 0, 0, 0, 0, 0, 1'b0, g);

        for (int r = 0; r < 25; r++) begin
            run_txn(16'($urandom), 16'($urandom), 1'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 2), ($urandom_range(0, 3) == 0), g);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
